// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the MIPS datapath.
// master = controller side, slave = datapath side.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic [2:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ext_zero;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       MemtoReg;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output state, ALUop, ALUSrcA, ALUSrcB, ext_zero, PCWrite, PCWriteCond,
           PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite,
           MemtoReg, instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  state, ALUop, ALUSrcA, ALUSrcB, ext_zero, PCWrite, PCWriteCond,
           PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite,
           MemtoReg, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback
// sequencing with a mem_ready handshake and a bounded wait in memory states.
module mc_main_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  mc_main_ctrl_if.master  bus
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       wait_st;
  logic       abort;

  logic [2:0] aluop;
  logic       srca, ez, pcw, pcwc, iord, mrd, mwr, irw, regdst, regw, m2r;
  logic       done, ill, tmo;
  logic [1:0] srcb, pcsrc;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);
  // Ready in the limit cycle wins, so the abort needs mem_ready low.
  assign abort   = wait_st && !bus.mem_ready && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    aluop   = 3'b000;
    srca    = 1'b0;
    srcb    = 2'b00;
    ez      = 1'b0;
    pcw     = 1'b0;
    pcwc    = 1'b0;
    pcsrc   = 2'b00;
    iord    = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    irw     = 1'b0;
    regdst  = 1'b0;
    regw    = 1'b0;
    m2r     = 1'b0;
    done    = 1'b0;
    ill     = 1'b0;
    tmo     = abort;

    unique case (state_q)
      S_FETCH: begin
        mrd     = 1'b1;
        srcb    = 2'b01;
        irw     = bus.mem_ready;
        pcw     = bus.mem_ready;
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        srcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_R:                      state_d = S_EXEC_R;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        srca    = 1'b1;
        srcb    = 2'b10;
        state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mrd     = 1'b1;
        iord    = 1'b1;
        state_d = bus.mem_ready ? S_MEM_WB : (abort ? S_FETCH : S_MEM_READ);
      end
      S_MEM_WB: begin
        regw = 1'b1;
        m2r  = 1'b1;
        done = 1'b1;
      end
      S_MEM_WRITE: begin
        mwr     = 1'b1;
        iord    = 1'b1;
        done    = bus.mem_ready;
        state_d = (bus.mem_ready || abort) ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        srca    = 1'b1;
        aluop   = 3'b010;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        regdst = 1'b1;
        regw   = 1'b1;
        done   = 1'b1;
      end
      S_BRANCH: begin
        srca  = 1'b1;
        aluop = 3'b001;
        pcwc  = 1'b1;
        pcsrc = 2'b01;
        done  = 1'b1;
      end
      S_JUMP: begin
        pcw   = 1'b1;
        pcsrc = 2'b10;
        done  = 1'b1;
      end
      S_EXEC_I: begin
        srca    = 1'b1;
        srcb    = 2'b10;
        state_d = S_I_WB;
        if (bus.opcode == OP_ANDI) begin
          aluop = 3'b100;
          ez    = 1'b1;
        end else if (bus.opcode == OP_ORI) begin
          aluop = 3'b101;
          ez    = 1'b1;
        end
      end
      S_I_WB: begin
        regw = 1'b1;
        done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Abort, or the clear on entering a state, both restart the wait count.
    if (abort || (state_d != state_q))
      cnt_d = '0;
    else if (wait_st && !bus.mem_ready)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;

    if (rst) begin
      pcw  = 1'b0;
      pcwc = 1'b0;
      mrd  = 1'b0;
      mwr  = 1'b0;
      irw  = 1'b0;
      regw = 1'b0;
      done = 1'b0;
      ill  = 1'b0;
      tmo  = 1'b0;
    end
  end

  assign bus.state       = state_q;
  assign bus.ALUop       = aluop;
  assign bus.ALUSrcA     = srca;
  assign bus.ALUSrcB     = srcb;
  assign bus.ext_zero    = ez;
  assign bus.PCWrite     = pcw;
  assign bus.PCWriteCond = pcwc;
  assign bus.PCSource    = pcsrc;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mrd;
  assign bus.MemWrite    = mwr;
  assign bus.IRWrite     = irw;
  assign bus.RegDst      = regdst;
  assign bus.RegWrite    = regw;
  assign bus.MemtoReg    = m2r;
  assign bus.instr_done  = done;
  assign bus.illegal_op  = ill;
  assign bus.mem_timeout = tmo;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: expected per-cycle outputs are queued when
// each step is driven and popped/compared at the following falling edge.
module tb_mc_main_ctrl;

  logic clk = 1'b0;
  logic rst;

  mc_main_ctrl_if bus ();

  mc_main_ctrl #(.WAIT_LIMIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       ez;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       regdst;
    logic       regw;
    logic       m2r;
    logic       done;
    logic       ill;
    logic       tmo;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Output table for each state taken directly from the controller description.
  function automatic obs_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                   input logic mr, input logic r, input logic tmo);
    obs_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; e.tmo = tmo; end
      4'd1: begin
        e.srcb = 2'b11;
        e.ill  = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b001000, 6'b001100, 6'b001101});
      end
      4'd2: begin e.srca = 1; e.srcb = 2'b10; end
      4'd3: begin e.mrd = 1; e.iord = 1; e.tmo = tmo; end
      4'd4: begin e.regw = 1; e.m2r = 1; e.done = 1; end
      4'd5: begin e.mwr = 1; e.iord = 1; e.done = mr; e.tmo = tmo; end
      4'd6: begin e.srca = 1; e.aluop = 3'b010; end
      4'd7: begin e.regdst = 1; e.regw = 1; e.done = 1; end
      4'd8: begin e.srca = 1; e.aluop = 3'b001; e.pcwc = 1; e.pcsrc = 2'b01; e.done = 1; end
      4'd9: begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
      4'd10: begin
        e.srca = 1; e.srcb = 2'b10;
        if (op == 6'b001100) begin e.aluop = 3'b100; e.ez = 1; end
        if (op == 6'b001101) begin e.aluop = 3'b101; e.ez = 1; end
      end
      4'd11: begin e.regw = 1; e.done = 1; end
      default: ;
    endcase
    if (r) begin
      e.pcw = 0; e.pcwc = 0; e.mrd = 0; e.mwr = 0; e.irw = 0;
      e.regw = 0; e.done = 0; e.ill = 0; e.tmo = 0;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state;       o.aluop = bus.ALUop;     o.srca = bus.ALUSrcA;
    o.srcb = bus.ALUSrcB;   o.ez = bus.ext_zero;     o.pcw = bus.PCWrite;
    o.pcwc = bus.PCWriteCond; o.pcsrc = bus.PCSource; o.iord = bus.IorD;
    o.mrd = bus.MemRead;    o.mwr = bus.MemWrite;    o.irw = bus.IRWrite;
    o.regdst = bus.RegDst;  o.regw = bus.RegWrite;   o.m2r = bus.MemtoReg;
    o.done = bus.instr_done; o.ill = bus.illegal_op; o.tmo = bus.mem_timeout;
    return o;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at negedge.
  task automatic step(input logic r, input logic mr, input logic [3:0] st,
                      input logic tmo, input string tag);
    obs_t e, o;
    rst           = r;
    bus.mem_ready = mr;
    exp_q.push_back(exp_out(st, bus.opcode, mr, r, tmo));
    @(negedge clk);
    o = sample();
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d)", tag, o, e, o.st, e.st);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 0, "reset_idle");

    // R-type
    step(0, 1, 0, 0, "r_fetch");
    step(0, 1, 1, 0, "r_decode");
    step(0, 1, 6, 0, "r_exec");
    step(0, 1, 7, 0, "r_wb");

    // reset held for two edges starting in EXEC_R
    step(0, 1, 0, 0, "r2_fetch");
    step(0, 1, 1, 0, "r2_decode");
    step(1, 1, 6, 0, "rst_in_exec");
    step(1, 1, 0, 0, "rst_in_fetch");
    step(0, 0, 0, 0, "post_rst_fetch");

    // lw with three wait cycles in MEM_READ
    bus.opcode = 6'b100011;
    step(0, 1, 0, 0, "lw_fetch");
    step(0, 1, 1, 0, "lw_decode");
    step(0, 1, 2, 0, "lw_addr");
    for (int i = 0; i < 3; i++) step(0, 0, 3, 0, "lw_wait");
    step(0, 1, 3, 0, "lw_ready");
    step(0, 1, 4, 0, "lw_wb");

    // lw that times out in MEM_READ
    step(0, 1, 0, 0, "lwto_fetch");
    step(0, 1, 1, 0, "lwto_decode");
    step(0, 1, 2, 0, "lwto_addr");
    for (int i = 0; i < 15; i++) step(0, 0, 3, 0, "lwto_wait");
    step(0, 0, 3, 1, "lwto_abort");

    // sw that times out in MEM_WRITE
    bus.opcode = 6'b101011;
    step(0, 1, 0, 0, "swto_fetch");
    step(0, 1, 1, 0, "swto_decode");
    step(0, 1, 2, 0, "swto_addr");
    for (int i = 0; i < 15; i++) step(0, 0, 5, 0, "swto_wait");
    step(0, 0, 5, 1, "swto_abort");

    // sw whose ready arrives in the limit cycle
    step(0, 1, 0, 0, "swlim_fetch");
    step(0, 1, 1, 0, "swlim_decode");
    step(0, 1, 2, 0, "swlim_addr");
    for (int i = 0; i < 15; i++) step(0, 0, 5, 0, "swlim_wait");
    step(0, 1, 5, 0, "swlim_ready");

    // I-type, branch, jump, illegal
    bus.opcode = 6'b001100;
    step(0, 1, 0, 0, "andi_fetch");
    step(0, 1, 1, 0, "andi_decode");
    step(0, 1, 10, 0, "andi_exec");
    step(0, 1, 11, 0, "andi_wb");
    bus.opcode = 6'b001101;
    step(0, 1, 0, 0, "ori_fetch");
    step(0, 1, 1, 0, "ori_decode");
    step(0, 1, 10, 0, "ori_exec");
    step(0, 1, 11, 0, "ori_wb");
    bus.opcode = 6'b001000;
    step(0, 1, 0, 0, "addi_fetch");
    step(0, 1, 1, 0, "addi_decode");
    step(0, 1, 10, 0, "addi_exec");
    step(0, 1, 11, 0, "addi_wb");
    bus.opcode = 6'b000100;
    step(0, 1, 0, 0, "beq_fetch");
    step(0, 1, 1, 0, "beq_decode");
    step(0, 1, 8, 0, "beq_branch");
    bus.opcode = 6'b000010;
    step(0, 1, 0, 0, "j_fetch");
    step(0, 1, 1, 0, "j_decode");
    step(0, 1, 9, 0, "j_jump");
    bus.opcode = 6'b111111;
    step(0, 1, 0, 0, "ill_fetch");
    step(0, 1, 1, 0, "ill_decode");

    // FETCH timeout stays in FETCH and restarts the count
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, "fto_wait");
    step(0, 0, 0, 1, "fto_abort");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, "fto_rewait");
    step(0, 0, 0, 1, "fto_abort2");
    bus.opcode = 6'b000000;
    step(0, 1, 0, 0, "fto_ready");
    step(0, 1, 1, 0, "fto_decode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
